// File: rtl/iwrr_pkg.sv
// Package shared by the IWRR weight tracker slice.
// Holds the tracker FSM state encoding and the two arithmetic helpers used by
// both the per-requester counter and the round-end detection in the top:
//   eff_weight_of : weight 0 is treated as 1 so no requester is ever starved
//   sat_inc       : counter increment that stops at the effective weight
package iwrr_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,  // every counter is zero, no round in progress
    S_ROUND = 1'b1   // at least one grant accepted this round
  } state_t;

  function automatic int unsigned eff_weight_of(input int unsigned weight);
    return (weight == 0) ? 1 : weight;
  endfunction

  // The effective weight never exceeds 2^W-1, so stopping at it also keeps
  // the counter from wrapping.
  function automatic int unsigned sat_inc(input int unsigned cnt,
                                          input int unsigned eff_weight);
    return (cnt >= eff_weight) ? cnt : cnt + 1;
  endfunction

endpackage

// File: rtl/iwrr_weight_tracker_if.sv
// Bus between the combinational priority granter side and the weight tracker.
//   request                  : raw request vector
//   weight                   : weight i at [i*W +: W]
//   grant                    : one-hot grant from the granter
//   grant_accept             : grant consumed downstream this cycle
//   request_weight_completed : requester i has used its weight this round
//   round_done               : registered 1-cycle pulse on round end
// master drives request/weight/grant/grant_accept; slave is the tracker.
interface iwrr_weight_tracker_if #(
  parameter int unsigned P_REQUESTER_NUM = 3,
  parameter int unsigned P_WEIGHT_W      = 4
);

  logic [P_REQUESTER_NUM-1:0]            request;
  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight;
  logic [P_REQUESTER_NUM-1:0]            grant;
  logic                                  grant_accept;
  logic [P_REQUESTER_NUM-1:0]            request_weight_completed;
  logic                                  round_done;

  modport master (
    output request, weight, grant, grant_accept,
    input  request_weight_completed, round_done
  );

  modport slave (
    input  request, weight, grant, grant_accept,
    output request_weight_completed, round_done
  );

endinterface

// File: rtl/iwrr_weight_cnt.sv
// Grant counter for one requester.
//   clk, rst_n  : clock, async active-low reset
//   inc         : an accepted grant targets this requester
//   clr         : round end / abandon, wins over inc
//   eff_weight  : effective (never zero) weight for this requester
//   cnt         : grants consumed this round, stops at eff_weight
//   completed   : cnt has reached eff_weight
module iwrr_weight_cnt
  import iwrr_pkg::*;
#(
  parameter int unsigned P_WEIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  clr,
  input  logic [P_WEIGHT_W-1:0] eff_weight,
  output logic [P_WEIGHT_W-1:0] cnt,
  output logic                  completed
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      // A completed requester granted alone holds at its weight.
      cnt <= P_WEIGHT_W'(sat_inc(32'(cnt), 32'(eff_weight)));
    end
  end

  assign completed = (cnt >= eff_weight);

endmodule

// File: rtl/iwrr_weight_tracker.sv
// Sequential credit stage of the IWRR arbiter.
// Counts accepted grants per requester against programmable weights, feeds
// request_weight_completed back to the granter with zero latency, and clears
// all counters when every still-requesting requester has used its weight.
//   clk, rst_n : clock, async active-low reset
//   bus        : iwrr_weight_tracker_if slave (request, weight, grant,
//                grant_accept in; request_weight_completed, round_done out)
// Optional feature macro IWRR_WEIGHT_LATCH_EN: when defined, weights are
// snapshotted on the first accepted grant of a round and held for that
// round; when undefined, the live weights are used every cycle.
module iwrr_weight_tracker
  import iwrr_pkg::*;
#(
  parameter int unsigned P_REQUESTER_NUM = 3,
  parameter int unsigned P_WEIGHT_W      = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  iwrr_weight_tracker_if.slave bus
);

  localparam int unsigned N = P_REQUESTER_NUM;
  localparam int unsigned W = P_WEIGHT_W;

  state_t              state, state_next;
  logic                acc, end_cond, clr, round_done_q;
  logic [N*W-1:0]      weight_src;
  logic [N-1:0][W-1:0] eff_weight, cnt, cnt_inc;
  logic [N-1:0]        covered, inc, completed;

  // A multi-hot grant is illegal; counting nothing keeps the counters sane.
  assign acc = bus.grant_accept & $onehot(bus.grant);

`ifdef IWRR_WEIGHT_LATCH_EN
  logic [N*W-1:0] wlat;

  // NOTE: every flop, including data-only ones like this snapshot, gets a
  // reset value so nothing is X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wlat <= '0;
    end else if (state == S_IDLE && acc) begin
      wlat <= bus.weight;
    end
  end

  assign weight_src = (state == S_ROUND) ? wlat : bus.weight;
`else
  assign weight_src = bus.weight;
`endif

  // Post-increment view of each counter, used to see whether this very
  // accept closes the round.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      eff_weight[i] = W'(eff_weight_of(32'(weight_src[i*W +: W])));
      cnt_inc[i]    = bus.grant[i] ? W'(sat_inc(32'(cnt[i]), 32'(eff_weight[i])))
                                   : cnt[i];
      covered[i]    = ~bus.request[i] | (cnt_inc[i] >= eff_weight[i]);
    end
  end

  assign end_cond = acc & (&covered);
  assign inc      = {N{acc}} & bus.grant;

  for (genvar g = 0; g < N; g++) begin : g_cnt
    iwrr_weight_cnt #(
      .P_WEIGHT_W (W)
    ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (inc[g]),
      .clr        (clr),
      .eff_weight (eff_weight[g]),
      .cnt        (cnt[g]),
      .completed  (completed[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      round_done_q <= 1'b0;
    end else begin
      state        <= state_next;
      round_done_q <= end_cond;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch
  // is inferred.
  always_comb begin
    state_next = state;
    clr        = 1'b0;
    case (state)
      S_IDLE: begin
        // A round finishing on its very first accept stays idle.
        if (end_cond) begin
          clr = 1'b1;
        end else if (acc) begin
          state_next = S_ROUND;
        end
      end
      S_ROUND: begin
        // With nobody requesting the round is abandoned without a pulse.
        if (end_cond || bus.request == '0) begin
          clr        = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.request_weight_completed = completed;
  assign bus.round_done               = round_done_q;

  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    bus.grant_accept |-> $onehot(bus.grant));

endmodule

// File: tb/tb_iwrr_weight_tracker.sv
module tb_iwrr_weight_tracker;

  localparam int N = 3;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iwrr_weight_tracker_if #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(W)) bus ();

  iwrr_weight_tracker #(
    .P_REQUESTER_NUM (N),
    .P_WEIGHT_W      (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  // Reference model: grant counts per requester, the pending round_done
  // pulse and the weight snapshot. A round is in progress iff any count is
  // nonzero.
  int             mcnt[N];
  bit             mrd;
  logic [N*W-1:0] mwlat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_round();
    for (int i = 0; i < N; i++) if (mcnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int eff_of(input int i);
    logic [W-1:0] w;
    w = bus.weight[i*W +: W];
`ifdef IWRR_WEIGHT_LATCH_EN
    if (in_round()) w = mwlat[i*W +: W];
`endif
    return (w == 0) ? 1 : int'(w);
  endfunction

  function automatic logic [N-1:0] exp_completed();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mcnt[i] >= eff_of(i));
    return r;
  endfunction

  // Applies the round rules for one clock edge using the inputs that were
  // stable across that edge.
  task automatic model_edge();
    int nxt[N];
    int eff[N];
    bit acc, all_cov, was_round;
    was_round = in_round();
    for (int i = 0; i < N; i++) eff[i] = eff_of(i);
    acc = bus.grant_accept && ($countones(bus.grant) == 1);
    nxt = mcnt;
    for (int i = 0; i < N; i++)
      if (acc && bus.grant[i] && nxt[i] < eff[i]) nxt[i]++;
    all_cov = 1'b1;
    for (int i = 0; i < N; i++)
      if (bus.request[i] && nxt[i] < eff[i]) all_cov = 1'b0;
`ifdef IWRR_WEIGHT_LATCH_EN
    if (!was_round && acc) mwlat = bus.weight;
`endif
    mrd = acc && all_cov;
    if (mrd || (was_round && bus.request == '0))
      for (int i = 0; i < N; i++) nxt[i] = 0;
    mcnt = nxt;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    mrd   = 1'b0;
    mwlat = '0;
  endtask

  // Single compare process: outputs are checked every falling edge.
  always @(negedge clk) begin
    if (run) begin
      check("completed", 32'(bus.request_weight_completed), 32'(exp_completed()));
      check("round_done", 32'(bus.round_done), 32'(mrd));
    end
  end

  task automatic cycle(input logic [N-1:0] req, input logic [N*W-1:0] w,
                       input logic [N-1:0] g, input logic a);
    bus.request      = req;
    bus.weight       = w;
    bus.grant        = g;
    bus.grant_accept = a;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] wts(input int w2, input int w1, input int w0);
    return {W'(w2), W'(w1), W'(w0)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

`ifdef IWRR_WEIGHT_LATCH_EN
  localparam int T6_LEN = 2;
`else
  localparam int T6_LEN = 4;
`endif

  initial begin
    int gs[6];
    logic [N-1:0] t1_comp[6];
    logic [N*W-1:0] w;
    logic [N-1:0] req, g;
    logic a;
    gs      = '{0, 1, 2, 1, 2, 2};
    t1_comp = '{3'b001, 3'b001, 3'b001, 3'b011, 3'b011, 3'b000};

    bus.request = '0; bus.weight = '0; bus.grant = '0; bus.grant_accept = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_completed", 32'(bus.request_weight_completed), 32'd0);
    check("reset_round_done", 32'(bus.round_done), 32'd0);
    #1 rst_n = 1'b1;
    run = 1'b1;

    // 1: weights {3,2,1}, grants 0,1,2,1,2,2
    for (int i = 0; i < 6; i++) begin
      cycle(3'b111, wts(3, 2, 1), 3'(1 << gs[i]), 1'b1);
      check("t1_completed", 32'(bus.request_weight_completed), 32'(t1_comp[i]));
      check("t1_round_done", 32'(bus.round_done), (i == 5) ? 32'd1 : 32'd0);
    end
    cycle(3'b111, wts(3, 2, 1), 3'b000, 1'b0);
    check("t1_after_pulse", 32'(bus.round_done), 32'd0);

    // 2: lone requester 1, weight 2
    cycle(3'b010, wts(0, 2, 0), 3'b010, 1'b1);
    check("t2_first", 32'({bus.round_done, bus.request_weight_completed}), 32'd0);
    cycle(3'b010, wts(0, 2, 0), 3'b010, 1'b1);
    check("t2_second", 32'({bus.round_done, bus.request_weight_completed}), 32'h8);

    // 3: weight 0 behaves as 1, every accept ends a round
    for (int i = 0; i < 3; i++) begin
      cycle(3'b001, wts(5, 5, 0), 3'b001, 1'b1);
      check("t3_zero_weight", 32'({bus.round_done, bus.request_weight_completed}), 32'h8);
    end

    // 4: grant without accept does not count
    cycle(3'b010, wts(0, 2, 0), 3'b010, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(3'b010, wts(0, 2, 0), 3'b010, 1'b0);
      check("t4_no_accept", 32'(bus.round_done), 32'd0);
    end
    cycle(3'b010, wts(0, 2, 0), 3'b010, 1'b1);
    check("t4_resume", 32'(bus.round_done), 32'd1);

    // 5: reset in the middle of a round
    cycle(3'b111, wts(2, 3, 3), 3'b010, 1'b1);
    cycle(3'b111, wts(2, 3, 3), 3'b100, 1'b1);
    cycle(3'b111, wts(2, 3, 3), 3'b100, 1'b1);
    check("t5_before_reset", 32'(bus.request_weight_completed), 32'b100);
    bus.grant_accept = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_reset_now", 32'({bus.round_done, bus.request_weight_completed}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cycle(3'b001, wts(2, 3, 2), 3'b001, 1'b1);
    check("t5_first_after", 32'({bus.round_done, bus.request_weight_completed}), 32'd0);
    cycle(3'b001, wts(2, 3, 2), 3'b001, 1'b1);
    check("t5_second_after", 32'(bus.round_done), 32'd1);

    // 6: weight 1 changes 2 -> 4 after the first accept of a round
    cycle(3'b010, wts(0, 2, 0), 3'b010, 1'b1);
    check("t6_first", 32'(bus.round_done), 32'd0);
    for (int k = 2; k <= T6_LEN; k++) begin
      cycle(3'b010, wts(0, 4, 0), 3'b010, 1'b1);
      check("t6_round_end", 32'(bus.round_done), (k == T6_LEN) ? 32'd1 : 32'd0);
    end
    cycle(3'b010, wts(0, 4, 0), 3'b010, 1'b1);
    cycle(3'b010, wts(0, 4, 0), 3'b010, 1'b1);
    cycle(3'b010, wts(0, 4, 0), 3'b010, 1'b1);
    check("t6_next_round_3", 32'(bus.round_done), 32'd0);
    cycle(3'b010, wts(0, 4, 0), 3'b010, 1'b1);
    check("t6_next_round_4", 32'(bus.round_done), 32'd1);

    // Randomized traffic checked by the compare process
    w = wts(3, 2, 1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(7) == 0) w = (N*W)'($urandom);
      req = ($urandom_range(7) == 0) ? '0 : N'($urandom);
      g   = N'(1 << $urandom_range(N - 1));
      a   = ($urandom_range(3) != 0);
      if (!a && $urandom_range(3) == 0) g = '0;
      cycle(req, w, g, a);
    end

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
